dic_disp_tx: RTL
================

Name: dic_disp_tx

Overview:
- Transmit-side companion to the digital-clock key decoder and clock FSM.
- On request, snapshots the current display digits (MM:SS) and alarm status, then emits an ASCII status line byte-by-byte to the UART transmitter through a valid/busy handshake.
- Sits between the clock datapath (BCD digit registers) and the UART TX, giving a serial echo of the clock state.

Parameters:
- SEND_CRLF, 1, 1 = append CR (0x0D) and LF (0x0A) to each line; 0 = frame ends after the alarm character.
- ALARM_CHAR, 8'h2A, character sent in slot 6 when alarm_ena=1 ('*'); a space (0x20) is sent when alarm_ena=0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- send_req  input  1  request to transmit one status line; level-sampled each cycle.
- di_Mtens  input  4  BCD minutes tens.
- di_Mones  input  4  BCD minutes ones.
- di_Stens  input  4  BCD seconds tens.
- di_Sones  input  4  BCD seconds ones.
- alarm_ena  input  1  alarm-enabled status, snapshotted with the digits.
- tx_busy  input  1  UART TX busy; a byte is accepted only while low.
- tx_data  output  8  byte to transmit; registered.
- tx_data_vld  output  1  one-cycle strobe qualifying tx_data; registered.
- frame_busy  output  1  high from snapshot until the last byte's WAIT completes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_data=8'h00, tx_data_vld=0, frame_busy=0, pending=0, byte index=0, snapshot registers=0.
- Frame byte order, index 0..7: Mtens, Mones, ':' (0x3A), Stens, Sones, alarm char, CR, LF. Frame length is 8 bytes when SEND_CRLF=1, otherwise 6.
- Digit encoding: value 0-9 maps to 0x30+value. Values 10-15 map to '?' (0x3F). Encoding is applied to the snapshot, never to the live inputs.
- IDLE:
  - On an edge with send_req=1 or pending=1: capture all four digits and alarm_ena into the snapshot, clear pending, set index=0, set frame_busy=1, go to SEND.
- SEND:
  - On an edge with tx_busy=0: tx_data<=char[index], tx_data_vld<=1, go to HOLD.
  - While tx_busy=1: stay in SEND; tx_data_vld stays 0.
- HOLD: exactly one cycle. tx_data_vld<=0, tx_data holds its value. Go to WAIT. This gives the UART one cycle to raise tx_busy.
- WAIT:
  - On an edge with tx_busy=0 and index=last: go to IDLE, frame_busy<=0.
  - On an edge with tx_busy=0 and index not last: index<=index+1, go to SEND.
  - While tx_busy=1: stay in WAIT.
- Latency: send_req sampled at edge N with tx_busy held low gives the first tx_data_vld high after edge N+1. Each byte then takes a minimum of 3 cycles (SEND, HOLD, WAIT), so a minimum 8-byte frame is 24 cycles.
- tx_data_vld is never high on two consecutive cycles. It is only asserted from SEND.
- send_req while frame_busy=1 sets pending=1. Only one pending request is held; further requests are dropped. The pending request starts the next frame on the edge after the frame returns to IDLE, with a fresh snapshot taken at that time.
- send_req held high continuously produces back-to-back frames with one IDLE cycle between them.
- Digit or alarm_ena changes mid-frame do not affect the frame in flight.
- Reset asserted mid-frame aborts immediately. No further bytes are sent, pending is cleared, and the first edge after release with send_req=1 begins a new frame at index 0.
- Index wraps only through IDLE. It never increments past the last index.

Test Plan:
- Digits 1,2,3,4, alarm_ena=0, SEND_CRLF=1, tx_busy tied 0, one-cycle send_req -> bytes 0x31,0x32,0x3A,0x33,0x34,0x20,0x0D,0x0A. First strobe one cycle after the request; strobes spaced exactly 3 cycles; frame_busy falls after the 8th WAIT.
- Digits 5,9,5,9, alarm_ena=1, SEND_CRLF=0 -> 0x35,0x39,0x3A,0x35,0x39,0x2A (6 bytes only), then IDLE.
- di_Stens=4'hC -> byte 3 is 0x3F. Changing di_Sones from 4 to 7 after the first strobe still yields 0x34 in byte 4.
- UART model raises tx_busy for 10 cycles after each strobe -> each byte is sent only after tx_busy falls. No strobe ever occurs while tx_busy=1, and all 8 bytes arrive in order.
- Three send_req pulses during an active frame -> exactly one extra frame follows, starting 1 cycle after frame_busy falls, using digits sampled at that point.
- rst pulled low after byte 3 with send_req pending -> outputs go to 0 immediately. After release with no send_req, no bytes are emitted. A later request yields a complete frame starting at Mtens.

Source files
------------

// File: rtl/dic_disp_tx.sv
// rtl/dic_disp_tx.sv - snapshots MM:SS and alarm status, streams an ASCII status line to the UART TX
module dic_disp_tx #(
    parameter bit         SEND_CRLF  = 1'b1,
    parameter logic [7:0] ALARM_CHAR = 8'h2A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [3:0] di_Mtens,
    input  logic [3:0] di_Mones,
    input  logic [3:0] di_Stens,
    input  logic [3:0] di_Sones,
    input  logic       alarm_ena,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_data_vld,
    output logic       frame_busy
);

    localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'd7 : 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t     state;
    logic       pending;
    logic [2:0] byteIdx;
    logic [3:0] snapMtens;
    logic [3:0] snapMones;
    logic [3:0] snapStens;
    logic [3:0] snapSones;
    logic       snapAlarm;
    logic [7:0] curChar;

    function automatic logic [7:0] digitChar(input logic [3:0] v);
        return (v <= 4'd9) ? (8'h30 + {4'h0, v}) : 8'h3F;
    endfunction

    // Characters are built only from the snapshot so live digit changes never leak into a frame.
    always_comb begin
        curChar = 8'h00;
        case (byteIdx)
            3'd0:    curChar = digitChar(snapMtens);
            3'd1:    curChar = digitChar(snapMones);
            3'd2:    curChar = 8'h3A;
            3'd3:    curChar = digitChar(snapStens);
            3'd4:    curChar = digitChar(snapSones);
            3'd5:    curChar = snapAlarm ? ALARM_CHAR : 8'h20;
            3'd6:    curChar = 8'h0D;
            3'd7:    curChar = 8'h0A;
            default: curChar = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            byteIdx     <= 3'd0;
            snapMtens   <= 4'd0;
            snapMones   <= 4'd0;
            snapStens   <= 4'd0;
            snapSones   <= 4'd0;
            snapAlarm   <= 1'b0;
            tx_data     <= 8'h00;
            tx_data_vld <= 1'b0;
            frame_busy  <= 1'b0;
        end else begin
            // One request is remembered while a frame is in flight; extras collapse into it.
            if (state != ST_IDLE && send_req) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (send_req || pending) begin
                        snapMtens  <= di_Mtens;
                        snapMones  <= di_Mones;
                        snapStens  <= di_Stens;
                        snapSones  <= di_Sones;
                        snapAlarm  <= alarm_ena;
                        pending    <= 1'b0;
                        byteIdx    <= 3'd0;
                        frame_busy <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data     <= curChar;
                        tx_data_vld <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Gives the UART a cycle to raise tx_busy before it is sampled again.
                    tx_data_vld <= 1'b0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx_busy) begin
                        if (byteIdx == LAST_IDX) begin
                            frame_busy <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            byteIdx <= byteIdx + 3'd1;
                            state   <= ST_SEND;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
